// File: rtl/serial_subtractor_4bit.sv
// ----------------------------------------------------------------------------
// serial_subtractor_4bit
//
// Bit-serial ripple-borrow subtractor: diff = a - b - borrow_in, computed one
// bit per clock, LSB first, through a single shared borrow cell. A start/done
// handshake lets a controller launch an operation and collect the result.
//
// Optional feature macro: SUB_OVERFLOW_EN
//   defined   -> adds the 'overflow' output (signed overflow of a - b).
//   undefined -> no overflow port or logic; everything else is identical.
//
// Handshake contract:
//   - start is sampled only while the FSM is IDLE. When it is seen high on a
//     rising edge the operands are latched and the operation begins; start
//     while SHIFT or DONE is ignored (no queueing, no re-latching).
//   - busy is high for the WIDTH cycles of SHIFT.
//   - done is a single-cycle pulse in the cycle after the last SHIFT edge;
//     diff / borrow_out / overflow are valid from that cycle until the next
//     accepted start. While busy, diff holds partial working data.
//   - With start held high, operations run back to back, one every WIDTH+2
//     cycles (accept edge, WIDTH shift edges, one DONE edge).
//
// Reset is asynchronous and active-high; it aborts any operation in flight
// and returns every output to zero without a done pulse.
//
// state_dbg exposes the FSM state (0 = IDLE, 1 = SHIFT, 2 = DONE) so that
// external checkers can observe it without reaching into the hierarchy.
// ----------------------------------------------------------------------------
module serial_subtractor_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done,
`ifdef SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [1:0]       state_dbg
);

  // Counter only needs to index bits 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] a_sh_q,       a_sh_d;       // minuend, shifted right each bit
  logic [WIDTH-1:0] b_sh_q,       b_sh_d;       // subtrahend, shifted right each bit
  logic             br_q,         br_d;         // running borrow between bits
  logic [WIDTH-1:0] diff_q,       diff_d;       // result, filled from the MSB side
  logic             borrow_out_q, borrow_out_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;
`ifdef SUB_OVERFLOW_EN
  logic             a_msb_q,      a_msb_d;      // sign bits kept for the overflow test
  logic             b_msb_q,      b_msb_d;
  logic             overflow_q,   overflow_d;
`endif

  // --------------------------------------------------------------------------
  // One-bit borrow cell, fed from the LSB of the operand shift registers
  // --------------------------------------------------------------------------
  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;

  // Full-subtractor cell: difference bit and outgoing borrow for bit i.
  always_comb begin
    a_bit   = a_sh_q[0];
    b_bit   = b_sh_q[0];
    d_bit   = a_bit ^ b_bit ^ br_q;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
  end

  // --------------------------------------------------------------------------
  // Next-state and next-output logic for the whole block
  // --------------------------------------------------------------------------
  // Everything holds by default; done is a pulse so it defaults low.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    br_d         = br_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef SUB_OVERFLOW_EN
    a_msb_d      = a_msb_q;
    b_msb_d      = b_msb_q;
    overflow_d   = overflow_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Capture the operands; later input changes cannot reach the
          // operation in flight because only the shift registers are used.
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
`ifdef SUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end

      ST_SHIFT: begin
        // Consume one bit per edge; the difference bit enters at the MSB so
        // that after WIDTH edges bit 0 has reached diff[0].
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        diff_d = {d_bit, diff_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);

        if (cnt_q == LAST_BIT) begin
          // Final bit: publish the borrow and finish on this same edge.
          state_d      = ST_DONE;
          busy_d       = 1'b0;
          done_d       = 1'b1;
          borrow_out_d = br_next;
          cnt_d        = '0;
`ifdef SUB_OVERFLOW_EN
          // Signed overflow: operand signs differ and the result sign
          // disagrees with the minuend. d_bit is the new diff MSB.
          overflow_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end

      ST_DONE: begin
        // One-cycle completion state; start is not looked at here.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers with asynchronous active-high reset
  // --------------------------------------------------------------------------
  // Single clocked process for the FSM and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      br_q         <= 1'b0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      a_msb_q      <= 1'b0;
      b_msb_q      <= 1'b0;
      overflow_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      br_q         <= br_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SUB_OVERFLOW_EN
      a_msb_q      <= a_msb_d;
      b_msb_q      <= b_msb_d;
      overflow_q   <= overflow_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from registers
  // --------------------------------------------------------------------------
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign state_dbg  = state_q;
`ifdef SUB_OVERFLOW_EN
  assign overflow   = overflow_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// ----------------------------------------------------------------------------
// tb_serial_subtractor_4bit
//
// Drives serial subtractions and checks each done pulse against a reference
// result computed with plain integer arithmetic (a - b - borrow_in), plus the
// cycle at which done is expected. Works with or without SUB_OVERFLOW_EN.
// ----------------------------------------------------------------------------
module tb_serial_subtractor_4bit;

  localparam int W  = 4;
  localparam int EW = 32 + 2 + W;   // {done_cycle, overflow, borrow, diff}

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;
  logic         overflow_obs;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  serial_subtractor_4bit #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done),
`ifdef SUB_OVERFLOW_EN
    .overflow   (overflow_obs),
`endif
    .state_dbg  (state_dbg)
  );

`ifndef SUB_OVERFLOW_EN
  assign overflow_obs = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned subtraction as integers; overflow from the sign rule.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ra,
                                             input logic [W-1:0] rb,
                                             input logic         rbin);
    int r;
    logic [W-1:0] d;
    logic bo;
    logic ov;
    r  = int'(ra) - int'(rb) - int'(rbin);
    d  = W'(r & ((1 << W) - 1));
    bo = (r < 0);
    ov = (ra[W-1] != rb[W-1]) && (d[W-1] != ra[W-1]);
`ifndef SUB_OVERFLOW_EN
    ov = 1'b0;
`endif
    return {ov, bo, d};
  endfunction

  task automatic push_exp(input logic [W-1:0] ra, input logic [W-1:0] rb,
                          input logic rbin, input int done_cyc);
    exp_q.push_back({32'(done_cyc), ref_model(ra, rb, rbin)});
  endtask

  task automatic scramble();
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: compares every done pulse with the head of the expected queue
  // --------------------------------------------------------------------------
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      if (prev_done) chk("done_single_cycle", 32'(done), 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          chk("diff",       32'(diff),         32'(e[W-1:0]));
          chk("borrow_out", 32'(borrow_out),   32'(e[W]));
`ifdef SUB_OVERFLOW_EN
          chk("overflow",   32'(overflow_obs), 32'(e[W+1]));
`endif
          chk("done_cycle", 32'(cyc),          e[EW-1 -: 32]);
          chk("busy_at_done", 32'(busy),       32'd0);
        end
      end
    end
    prev_done = done && !reset;
  end

  // --------------------------------------------------------------------------
  // Driver tasks (caller is at a point where the DUT is known to be IDLE)
  // --------------------------------------------------------------------------
  // One operation; poke=1 pulses start with different operands mid-operation.
  task automatic issue(input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic rbin, input bit poke);
    @(negedge clk);
    a = ra; b = rb; borrow_in = rbin; start = 1'b1;
    @(negedge clk);               // accept edge has passed
    start = 1'b0;
    scramble();
    push_exp(ra, rb, rbin, cyc + W);
    chk("busy_after_accept", 32'(busy), 32'd1);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (poke && i == 0) begin
        start = 1'b1;
        a = ~ra; b = ~rb; borrow_in = ~rbin;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  // n operations with start held high throughout.
  task automatic back_to_back(input int n);
    logic [W-1:0] ra, rb;
    logic rbin;
    @(negedge clk);
    for (int k = 0; k < n; k++) begin
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      a = ra; b = rb; borrow_in = rbin; start = 1'b1;
      push_exp(ra, rb, rbin, cyc + 1 + W);
      for (int j = 0; j < W + 2; j++) begin
        @(negedge clk);
        if (j < W + 1) scramble();
      end
    end
    start = 1'b0;               // DUT is IDLE here; this start is not taken
  endtask

  // Start an operation, then reset it two cycles in.
  task automatic reset_mid_op();
    @(negedge clk);
    scramble(); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy",       32'(busy),         32'd0);
    chk("abort_done",       32'(done),         32'd0);
    chk("abort_diff",       32'(diff),         32'd0);
    chk("abort_borrow_out", 32'(borrow_out),   32'd0);
    chk("abort_overflow",   32'(overflow_obs), 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_diff",       32'(diff),         32'd0);
    chk("reset_borrow_out", 32'(borrow_out),   32'd0);
    chk("reset_busy",       32'(busy),         32'd0);
    chk("reset_done",       32'(done),         32'd0);
    chk("reset_overflow",   32'(overflow_obs), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_busy", 32'(busy), 32'd0);

    // Directed cases
    issue(4'd7,  4'd3,  1'b0, 1'b0);
    issue(4'd3,  4'd7,  1'b0, 1'b0);
    issue(4'd0,  4'd0,  1'b1, 1'b0);
    issue(4'd15, 4'd15, 1'b0, 1'b0);
    issue(4'd7,  4'd15, 1'b0, 1'b0);
    issue(4'd8,  4'd0,  1'b1, 1'b0);

    // Start pulsed mid-operation with other operands: must be ignored
    issue(4'd9,  4'd4,  1'b0, 1'b1);
    issue(4'd2,  4'd11, 1'b1, 1'b1);

    // Reset mid-operation, then a clean operation
    reset_mid_op();
    issue(4'd12, 4'd5,  1'b1, 1'b0);

    // Exhaustive sweep
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          issue(W'(ia), W'(ib), 1'(ic), 1'b0);

    // Random operations with random idle gaps and occasional ignored starts
    for (int r = 0; r < 150; r++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Back-to-back throughput
    back_to_back(6);

    // Drain with a bounded wait
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global guard against a stalled run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
